lsu_bus: RTL

LSU_BUS -- requirements
Module: lsu_bus

---
 rtl/lsu_bus.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus.sv
// lsu_bus: RISC-V load/store unit bridging the pipeline to a single-port, lane-masked memory bus.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two beats; otherwise they are rejected.
module lsu_bus #(
   parameter int XLEN = 32,
   parameter int AW   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [AW-1:0]     req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [XLEN/8-1:0] mem_mask,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [2:0] {
      IDLE, REQ1, RSP1,
`ifdef LSU_MISALIGN_EN
      REQ2, RSP2,
`endif
      DONE
   } state_t;

   state_t          state_q;
   logic            store_q, err_q;
   logic [2:0]      f3_q;
   logic [OW-1:0]   off_q;
   logic [AW-1:0]   base_q;
   logic            rsp_valid_q, rsp_err_q, mem_req_q, mem_we_q;
   logic [XLEN-1:0] rsp_rdata_q, mem_wdata_q;
   logic [AW-1:0]   mem_addr_q;
   logic [NB-1:0]   mem_mask_q;
`ifdef LSU_MISALIGN_EN
   logic            split_q;
   logic [NB-1:0]   mhi_q;
   logic [XLEN-1:0] whi_q, lo_q, whi_c;
`endif

   logic [OW-1:0]   off_c;
   logic [AW-1:0]   base_c;
   logic [2*NB-1:0] run_c, mask_c;
   logic [XLEN-1:0] wsz_c, wlo_c, ld_c;
   logic            legal_c, mis_c, err_c;

   // Sign/zero extension by shifting the sized field to the top and back down.
   function automatic logic [XLEN-1:0] ext(input logic [2:0] f, input logic [XLEN-1:0] d);
      logic [XLEN-1:0] t;
      int              sa;
      sa = XLEN - (8 << f[1:0]);
      t  = d << sa;
      if (f[2]) return t >> sa;
      return XLEN'($signed(t) >>> sa);
   endfunction

   always_comb begin
      off_c   = req_addr[OW-1:0];
      base_c  = {req_addr[AW-1:OW], {OW{1'b0}}};
      run_c   = req_funct3[1:0] == 2'd0 ? (2*NB)'(1) :
                req_funct3[1:0] == 2'd1 ? (2*NB)'(3) :
                req_funct3[1:0] == 2'd2 ? (2*NB)'(15) : (2*NB)'(255);
      mask_c  = run_c << off_c;
      mis_c   = |mask_c[2*NB-1:NB];
      legal_c = req_store ? !req_funct3[2] && (req_funct3[1:0] != 2'd3 || XLEN == 64)
                          : req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} ||
                            (XLEN == 64 && req_funct3 inside {3'd3, 3'd6});
      for (int i = 0; i < NB; i++) wsz_c[8*i +: 8] = req_wdata[8*i +: 8] & {8{run_c[i]}};
      wlo_c   = wsz_c << {off_c, 3'b000};
`ifdef LSU_MISALIGN_EN
      whi_c   = wsz_c >> (XLEN - 8 * int'(off_c));
      err_c   = !legal_c;
      ld_c    = ext(f3_q, XLEN'((state_q == RSP2 ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata})
                                >> {off_q, 3'b000}));
`else
      err_c   = !legal_c || mis_c;
      ld_c    = ext(f3_q, mem_rdata >> {off_q, 3'b000});
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         store_q     <= 1'b0;
         err_q       <= 1'b0;
         f3_q        <= '0;
         off_q       <= '0;
         base_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_mask_q  <= '0;
         mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_EN
         split_q     <= 1'b0;
         mhi_q       <= '0;
         whi_q       <= '0;
         lo_q        <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         // A granted beat drops the bus; a following beat re-drives it below.
         if (mem_gnt) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_mask_q  <= '0;
            mem_wdata_q <= '0;
         end
         case (state_q)
            IDLE: if (req_valid) begin
               state_q     <= REQ1;
               store_q     <= req_store;
               f3_q        <= req_funct3;
               off_q       <= off_c;
               err_q       <= err_c;
               base_q      <= base_c;
               mem_req_q   <= !err_c;
               mem_we_q    <= req_store && !err_c;
               mem_addr_q  <= err_c ? '0 : base_c;
               mem_mask_q  <= err_c ? '0 : mask_c[NB-1:0];
               mem_wdata_q <= req_store && !err_c ? wlo_c : '0;
`ifdef LSU_MISALIGN_EN
               split_q     <= mis_c;
               mhi_q       <= mask_c[2*NB-1:NB];
               whi_q       <= whi_c;
`endif
            end
            REQ1: if (err_q) begin
               state_q     <= DONE;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b1;
            end else if (mem_gnt) begin
`ifdef LSU_MISALIGN_EN
               if (store_q && split_q) begin
                  state_q     <= REQ2;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= base_q + AW'(NB);
                  mem_mask_q  <= mhi_q;
                  mem_wdata_q <= whi_q;
               end else
`endif
               if (store_q) begin
                  state_q     <= DONE;
                  rsp_valid_q <= 1'b1;
               end else state_q <= RSP1;
            end
            RSP1: if (mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
               if (split_q) begin
                  state_q    <= REQ2;
                  lo_q       <= mem_rdata;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= base_q + AW'(NB);
                  mem_mask_q <= mhi_q;
               end else
`endif
               begin
                  state_q     <= DONE;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= ld_c;
               end
            end
`ifdef LSU_MISALIGN_EN
            REQ2: if (mem_gnt) begin
               state_q     <= store_q ? DONE : RSP2;
               rsp_valid_q <= store_q;
            end
            RSP2: if (mem_rvalid) begin
               state_q     <= DONE;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= ld_c;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = state_q == IDLE;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_mask  = mem_mask_q;
   assign mem_wdata = mem_wdata_q;
endmodule
